// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling FSM,
// sticky word-ready / overrun flags and a one-cycle framing-error pulse.
module uart_rx_deserializer #(
   parameter int WORD_LENGTH = 8,
   parameter int BIT_TICKS   = 434
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   SerialDataIn,
   input  logic                   clearInterrupt,
   output logic [WORD_LENGTH-1:0] ReceivedData,
   output logic                   interrupt_bit,
   output logic                   framing_error,
   output logic                   overrun_error
);

   localparam int TW = $clog2(BIT_TICKS);
   localparam int BW = $clog2(WORD_LENGTH + 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(BIT_TICKS - 1);
   localparam logic [TW-1:0] TICK_HALF = TW'(BIT_TICKS / 2 - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_LENGTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } state_e;

   state_e                 state_q, state_d;
   logic                   sync1_q, rx_s_q;
   logic [TW-1:0]          tick_q, tick_d;
   logic [BW-1:0]          bit_q, bit_d;
   logic [WORD_LENGTH-1:0] shift_q, shift_d;
   logic [WORD_LENGTH-1:0] data_q, data_d;
   logic                   irq_q, irq_d;
   logic                   fe_q, fe_d;
   logic                   ovr_q, ovr_d;
   logic                   tick_end, half_end, stop_ok;

   assign tick_end = (tick_q == TICK_LAST);
   assign half_end = (tick_q == TICK_HALF);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b1;
         rx_s_q  <= 1'b1;
         state_q <= IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         irq_q   <= 1'b0;
         fe_q    <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         sync1_q <= SerialDataIn;
         rx_s_q  <= sync1_q;
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         irq_q   <= irq_d;
         fe_q    <= fe_d;
         ovr_q   <= ovr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      fe_d    = 1'b0;
      stop_ok = 1'b0;
      unique case (state_q)
         IDLE: begin
            tick_d = '0;
            bit_d  = '0;
            if (!rx_s_q) state_d = START;
         end
         START: begin
            if (half_end) begin
               tick_d  = '0;
               state_d = rx_s_q ? IDLE : DATA;
            end else begin
               tick_d = tick_q + TW'(1);
            end
         end
         DATA: begin
            if (tick_end) begin
               tick_d  = '0;
               shift_d = {rx_s_q, shift_q[WORD_LENGTH-1:1]};
               if (bit_q == BIT_LAST) begin
                  bit_d   = '0;
                  state_d = STOP;
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end else begin
               tick_d = tick_q + TW'(1);
            end
         end
         STOP: begin
            if (tick_end) begin
               tick_d = '0;
               if (rx_s_q) begin
                  stop_ok = 1'b1;
                  data_d  = shift_q;
                  state_d = IDLE;
               end else begin
                  fe_d    = 1'b1;
                  state_d = WAIT_HIGH;
               end
            end else begin
               tick_d = tick_q + TW'(1);
            end
         end
         WAIT_HIGH: begin
            tick_d = '0;
            if (rx_s_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A completed word beats a coincident clear; overrun only if uncleared.
      irq_d = irq_q;
      ovr_d = ovr_q;
      if (clearInterrupt) begin
         irq_d = 1'b0;
         ovr_d = 1'b0;
      end
      if (stop_ok) begin
         irq_d = 1'b1;
         if (irq_q && !clearInterrupt) ovr_d = 1'b1;
      end
   end

   assign ReceivedData  = data_q;
   assign interrupt_bit = irq_q;
   assign framing_error = fe_q;
   assign overrun_error = ovr_q;

endmodule

// File: doc/uart_rx_deserializer.md
# uart_rx_deserializer

UART receiver that converts the serial RX line into parallel words and flags each completed word on `interrupt_bit`. It sits directly upstream of the matrix/vector frame receiver. That receiver consumes `ReceivedData`, reads `interrupt_bit` as "byte ready", and pulses `clearInterrupt` once it has taken the byte. The format is 8N1, LSB first, with a fixed integer clock-per-bit divider, and the block runs in the system `clk` domain (50 MHz).

## Interface
- `WORD_LENGTH`, 8: data bits per character.
- `BIT_TICKS`, 434: clk cycles per bit (50 MHz / 115200 baud); must be ≥ 8 and even.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `SerialDataIn`  in  1  raw RX pin, asynchronous to `clk`; idles high.
- `clearInterrupt`  in  1  one-cycle pulse from the consumer; clears `interrupt_bit` and `overrun_error`.
- `ReceivedData`  out  WORD_LENGTH  last good word, LSB = first data bit received.
- `interrupt_bit`  out  1  sticky "word ready" flag.
- `framing_error`  out  1  one-cycle pulse when the stop bit samples 0.
- `overrun_error`  out  1  sticky; a new word completed while `interrupt_bit` was still 1.

## Operation
- Input synchronizer:
  - Two-flop synchronizer on `SerialDataIn`, giving `rx_s`.
  - Both flops reset to 1.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: bit counter = 0, tick counter = 0. On `rx_s` = 0, go to START.
  - START: count BIT_TICKS/2 ticks, then sample `rx_s`.
    - Sample 0: valid start. Go to DATA with the tick counter cleared.
    - Sample 1: false start (glitch). Return to IDLE with no output change.
  - DATA: every BIT_TICKS ticks, sample `rx_s` into the shift register.
    - Shift right, so the MSB enters last and bit 0 is the first bit received.
    - After WORD_LENGTH samples, go to STOP.
  - STOP: after BIT_TICKS ticks, sample `rx_s`.
    - Sample 1: load `ReceivedData` from the shift register and set `interrupt_bit`. If `interrupt_bit` was already 1, also set `overrun_error`; the new word overwrites the old one. Go to IDLE.
    - Sample 0: pulse `framing_error` for 1 cycle. `ReceivedData` and `interrupt_bit` are unchanged. Go to WAIT_HIGH.
  - WAIT_HIGH: remain until `rx_s` = 1 (break / line-low condition), then go to IDLE.
- Counters:
  - Tick counter is ceil(log2(BIT_TICKS)) bits wide and wraps to 0 at BIT_TICKS-1.
  - Bit counter is ceil(log2(WORD_LENGTH+1)) bits wide.
- `clearInterrupt`:
  - A pulse clears `interrupt_bit` and `overrun_error` on the next edge.
  - If it coincides with a successful stop-bit sample, set wins: `interrupt_bit` = 1 and the new data is loaded. `overrun_error` is not set in that case.
  - Has no effect on `ReceivedData`.
- Reset:
  - Asserting reset at any time, including mid-frame, aborts the frame immediately: FSM to IDLE, counters 0.
  - After deassertion the block waits for a fresh falling edge. A line that is already low after release is treated as a start candidate.

## Timing
- Reset values: `ReceivedData` = 0, `interrupt_bit` = 0, `framing_error` = 0, `overrun_error` = 0, synchronizer flops = 1, FSM = IDLE.
- Time reference E0 is the first rising edge at which the raw pin is captured low.
  - `rx_s` is low after E1.
  - START is entered at E2.
- Sample edges:
  - Start-bit sample at E2+BIT_TICKS/2.
  - Data bit i (i = 0..WORD_LENGTH-1) at E2+BIT_TICKS/2+(i+1)·BIT_TICKS.
  - Stop-bit sample at E2+BIT_TICKS/2+(WORD_LENGTH+1)·BIT_TICKS.
- `ReceivedData`, `interrupt_bit`, `overrun_error` and `framing_error` are registered and become visible immediately after the stop-sample edge.
- Back-to-back frames:
  - The next start bit may begin on the pin ½ bit after the stop-bit sample (normal 1-stop-bit spacing).
  - IDLE is re-entered in time, so no characters are lost.
- Glitch rejection: a pin low pulse shorter than BIT_TICKS/2−2 cycles never reaches DATA.

## Test plan
- Frame bytes, BIT_TICKS = 16: send FE, 03, 01, 03, EF back to back with `clearInterrupt` pulsed 2 cycles after each `interrupt_bit` rise.
  - Required: five `interrupt_bit` rises, with `ReceivedData` = FE, 03, 01, 03, EF in order.
  - Required: each rise lands exactly at the stop-sample edge computed above; no errors.
- Glitch: drive the pin low for 4 cycles, then high.
  - Required: FSM returns to IDLE; `interrupt_bit` stays 0 and `ReceivedData` is unchanged.
- Framing: send 0x55 with the stop bit forced to 0, holding the line low for 3 more bits, then send 0xA3.
  - Required: one `framing_error` pulse, with `ReceivedData` unchanged.
  - Required: then 0xA3 is received with `interrupt_bit` = 1.
- Overrun and collision, in two steps:
  - Receive 0x12 and 0x34 without clearing. Required: `ReceivedData` = 0x34, `interrupt_bit` = 1, `overrun_error` = 1. Then `clearInterrupt`: both flags go to 0 while `ReceivedData` stays 0x34.
  - Pulse `clearInterrupt` on the exact stop-sample edge of 0x56. Required: `interrupt_bit` = 1, `ReceivedData` = 0x56, `overrun_error` = 0.
- Reset: assert `reset` during data bit 4 of 0x9C, release, then send 0x21.
  - Required: all outputs go to 0 asynchronously, before the next clk edge; no word is produced from 0x9C.
  - Required: 0x21 is received correctly.
